// File: rtl/wave_pkg.sv
// Shared types and constants for the oscilloscope trace renderer.
package wave_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam int NPTS     = 800;
    localparam int BASE_ROW = 427;
    localparam int OFF_W    = 10;
    localparam int RAM_AW   = OFF_W + 1;

    localparam logic [19:0] AUTO_TO_DEFAULT = 20'd500000;

    localparam logic [23:0] C_BG    = 24'h000000;
    localparam logic [23:0] C_GRID  = 24'h404040;
    localparam logic [23:0] C_TRACE = 24'h00FF00;
    localparam logic [23:0] C_LEVEL = 24'hFFFF00;

    // Screen row for an 8-bit sample; 255 maps to row 172, so never negative.
    function automatic logic [9:0] sampleRow(input logic [7:0] s);
        return 10'(BASE_ROW) - {2'b00, s};
    endfunction

endpackage

// File: rtl/wave_ram.sv
// Two-bank sample store: one write port, one registered read port.
// The bank bit is the MSB of each port address; the lower bits are the
// sample offset within the bank. Banks are packed back to back so the
// array is exactly two records deep.
module wave_ram #(
    parameter int DW         = 8,
    parameter int BANK_DEPTH = 800,
    parameter int OW         = 10
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [OW:0]   waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [OW:0]   raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int AW = OW + 1;

    logic [DW-1:0] mem_q [0:2*BANK_DEPTH-1];
    logic [DW-1:0] rdata_q;

    function automatic logic [AW-1:0] linearIndex(input logic [AW-1:0] a);
        return a[OW] ? AW'(BANK_DEPTH) + {1'b0, a[OW-1:0]} : {1'b0, a[OW-1:0]};
    endfunction

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[linearIndex(waddr_i)] <= wdata_i;
        end
        rdata_q <= mem_q[linearIndex(raddr_i)];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wave_render.sv
// Oscilloscope trace renderer: captures one triggered 800-sample record
// into the back bank and draws the front bank as a trace over a grid,
// swapping banks only at the start of a frame.
module wave_render
    import wave_pkg::*;
#(
    parameter logic [19:0] AUTO_TO = AUTO_TO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  adc_data,
    input  logic        adc_valid,
    input  logic [7:0]  trig_level,
    input  logic        run,
    input  logic        arm,
    input  logic        vga_vs,
    input  logic [9:0]  hx,
    input  logic [9:0]  vy,
    output logic [23:0] RGB,
    output logic        triggered,
    output logic        auto_trig
);

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  prev_q, prev_d;
    logic        bank_q, bank_d;
    logic        autoPend_q, autoPend_d;
    logic        autoTrig_q, autoTrig_d;
    logic        vsPrev_q;
    logic        fs;
    logic        edgeHit;

    logic        we;
    logic [10:0] waddr;
    logic [10:0] raddr;
    logic [7:0]  rdata;

    logic [9:0]  hx1_q, vy1_q;
    logic        inRange1_q;
    logic [9:0]  lastRow_q;
    logic [23:0] rgb_q, rgb_d;

    logic [9:0]  curRow, lastUse, rowLo, rowHi, levelRow;
    logic        traceHit, levelHit, gridHit;

    assign fs        = vsPrev_q & ~vga_vs;
    assign edgeHit   = (prev_q < trig_level) && (adc_data >= trig_level);
    assign triggered = (state_q == CAPTURE) || (state_q == HOLD);
    assign auto_trig = autoTrig_q;
    assign RGB       = rgb_q;

    // Capture FSM next state; IDLE reacts every cycle so a one-cycle arm is never lost.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        bank_d     = bank_q;
        autoPend_d = autoPend_q;
        autoTrig_d = autoTrig_q;
        we         = 1'b0;
        waddr      = {~bank_q, addr_q};
        if (adc_valid) begin
            prev_d = adc_data;
        end
        unique case (state_q)
            IDLE: begin
                if (run || arm) begin
                    state_d = WAIT_TRIG;
                    cnt_d   = '0;
                end
            end
            WAIT_TRIG: begin
                if (adc_valid) begin
                    if (edgeHit || (cnt_q == AUTO_TO - 20'd1)) begin
                        we         = 1'b1;
                        waddr      = {~bank_q, 10'd0};
                        addr_d     = 10'd1;
                        autoPend_d = ~edgeHit;
                        cnt_d      = '0;
                        state_d    = CAPTURE;
                    end else begin
                        cnt_d = cnt_q + 20'd1;
                    end
                end
            end
            CAPTURE: begin
                if (adc_valid) begin
                    we     = 1'b1;
                    addr_d = addr_q + 10'd1;
                    if (addr_q == 10'(NPTS - 1)) begin
                        addr_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (fs) begin
                    bank_d     = ~bank_q;
                    autoTrig_d = autoPend_q;
                    cnt_d      = '0;
                    state_d    = run ? WAIT_TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture state registers and frame-start edge detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            prev_q     <= '0;
            bank_q     <= 1'b0;
            autoPend_q <= 1'b0;
            autoTrig_q <= 1'b0;
            vsPrev_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            bank_q     <= bank_d;
            autoPend_q <= autoPend_d;
            autoTrig_q <= autoTrig_d;
            vsPrev_q   <= vga_vs;
        end
    end

    // Columns past the record read offset 0 and are forced to background later.
    assign raddr = {bank_q, (hx < 10'(NPTS)) ? hx : 10'd0};

    wave_ram #(
        .DW         (8),
        .BANK_DEPTH (NPTS),
        .OW         (OFF_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (adc_data),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Stage 2 pixel classification; trace spans previous and current rows for continuity.
    always_comb begin
        curRow   = sampleRow(rdata);
        lastUse  = (hx1_q == 10'd0) ? curRow : lastRow_q;
        rowLo    = (lastUse < curRow) ? lastUse : curRow;
        rowHi    = (lastUse < curRow) ? curRow : lastUse;
        levelRow = sampleRow(trig_level);
        traceHit = (vy1_q >= rowLo) && (vy1_q <= rowHi);
        levelHit = (vy1_q == levelRow) && !hx1_q[2];
        gridHit  = (hx1_q[5:0] == 6'd0) || (vy1_q[5:0] == 6'd0);
        rgb_d    = C_BG;
        if (inRange1_q) begin
            if (traceHit) begin
                rgb_d = C_TRACE;
            end else if (levelHit) begin
                rgb_d = C_LEVEL;
            end else if (gridHit) begin
                rgb_d = C_GRID;
            end
        end
    end

    // Render pipeline registers: stage 1 aligns coordinates with the RAM read, stage 2 registers colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            hx1_q      <= '0;
            vy1_q      <= '0;
            inRange1_q <= 1'b0;
            lastRow_q  <= '0;
            rgb_q      <= '0;
        end else begin
            hx1_q      <= hx;
            vy1_q      <= vy;
            inRange1_q <= (hx < 10'(NPTS));
            lastRow_q  <= curRow;
            rgb_q      <= rgb_d;
        end
    end

endmodule

// File: tb/tb_wave_render.sv
// Self-checking bench for wave_render: scalar checks on the capture FSM
// outputs and a queue-based scoreboard for rendered pixels.
module tb_wave_render;

   localparam logic [23:0] BG    = 24'h000000;
   localparam logic [23:0] GRID  = 24'h404040;
   localparam logic [23:0] TRACE = 24'h00FF00;
   localparam logic [23:0] LEVEL = 24'hFFFF00;
   localparam int          TB_AUTO_TO = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  adc_data = '0;
   logic        adc_valid = 1'b0;
   logic [7:0]  trig_level = '0;
   logic        run = 1'b0;
   logic        arm = 1'b0;
   logic        vga_vs = 1'b1;
   logic [9:0]  hx = '0;
   logic [9:0]  vy = '0;
   logic [23:0] RGB;
   logic        triggered;
   logic        auto_trig;

   typedef struct packed {
      logic        v;
      logic [23:0] c;
   } slot_t;

   slot_t      pipeQ[$];
   logic [7:0] bankMem [0:1][0:799];
   int         frontBank = 0;
   int         checks = 0;
   int         passes = 0;
   bit         rdy;
   logic [23:0] got, exp;
   logic [7:0] rec [0:799];

   wave_render #(.AUTO_TO(20'(TB_AUTO_TO))) dut (
      .clk        (clk),
      .rst        (rst),
      .adc_data   (adc_data),
      .adc_valid  (adc_valid),
      .trig_level (trig_level),
      .run        (run),
      .arm        (arm),
      .vga_vs     (vga_vs),
      .hx         (hx),
      .vy         (vy),
      .RGB        (RGB),
      .triggered  (triggered),
      .auto_trig  (auto_trig)
   );

   // 100 MHz pixel clock
   always #5 clk = ~clk;

   // Expected colour of pixel (x,y) when columns are scanned left to right
   function automatic logic [23:0] expPix(int x, int y);
      int cur, last;
      if (x >= 800) return BG;
      cur  = 427 - int'(bankMem[frontBank][x]);
      last = (x == 0) ? cur : 427 - int'(bankMem[frontBank][x-1]);
      if ((y >= cur && y <= last) || (y >= last && y <= cur)) return TRACE;
      if (y == 427 - int'(trig_level) && ((x >> 2) & 1) == 0) return LEVEL;
      if ((x % 64) == 0 || (y % 64) == 0) return GRID;
      return BG;
   endfunction

   // One valid ADC sample, leaves the bench on a falling edge
   task sendSample(input logic [7:0] d);
      adc_data  = d;
      adc_valid = 1'b1;
      @(negedge clk);
      adc_valid = 1'b0;
   endtask

   // Falling edge on vga_vs held for one cycle
   task frameStart;
      vga_vs = 1'b0;
      @(negedge clk);
      vga_vs = 1'b1;
      @(negedge clk);
   endtask

   // One arm pulse of a single cycle
   task pulseArm;
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   // Advance one pixel slot: pop the pixel driven two cycles ago, drive the next
   task pixelStep(input int x, input int y, input bit drv,
                  output bit ready, output logic [23:0] g, output logic [23:0] e);
      slot_t s;
      @(negedge clk);
      ready = 1'b0;
      g     = RGB;
      e     = '0;
      if (pipeQ.size() == 2) begin
         s     = pipeQ.pop_front();
         ready = s.v;
         e     = s.c;
      end
      if (drv) begin
         hx = 10'(x);
         vy = 10'(y);
      end
      s.v = drv;
      s.c = drv ? expPix(x, y) : BG;
      pipeQ.push_back(s);
   endtask

   // Reset values of all outputs
   task test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (RGB !== 24'h0) $display("[TB] FAIL reset_rgb got=%h exp=000000", RGB); else passes++;
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL reset_trig got=%b exp=0", triggered); else passes++;
      checks++; if (auto_trig !== 1'b0) $display("[TB] FAIL reset_auto got=%b exp=0", auto_trig); else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Rising ramp crossing level 128, continuous run, then render after swap
   task test_ramp;
      int rows [3] = '{299, 300, 64};
      trig_level = 8'd128;
      run = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 128; i++) sendSample(8'(i));
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL ramp_pretrig got=%b exp=0", triggered); else passes++;
      for (int i = 0; i < 800; i++) begin
         bankMem[1-frontBank][i] = 8'((128 + i) % 256);
         sendSample(8'((128 + i) % 256));
         if (i == 0) begin
            checks++; if (triggered !== 1'b1) $display("[TB] FAIL ramp_trig got=%b exp=1", triggered); else passes++;
         end
      end
      repeat (3) sendSample(8'd7);
      checks++; if (triggered !== 1'b1) $display("[TB] FAIL ramp_hold got=%b exp=1", triggered); else passes++;
      frameStart();
      frontBank ^= 1;
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL ramp_rearm got=%b exp=0", triggered); else passes++;
      checks++; if (auto_trig !== 1'b0) $display("[TB] FAIL ramp_auto got=%b exp=0", auto_trig); else passes++;
      foreach (rows[r]) begin
         pipeQ.delete();
         for (int k = 0; k <= 807; k++) begin
            pixelStep(k, rows[r], k <= 805, rdy, got, exp);
            if (rdy) begin
               checks++;
               if (got !== exp) $display("[TB] FAIL ramp_pix x=%0d y=%0d got=%h exp=%h", k-2, rows[r], got, exp);
               else passes++;
            end
         end
      end
   endtask

   // Flat input never crosses the level: forced trigger after AUTO_TO samples
   task test_auto;
      int rows [3] = '{417, 416, 227};
      trig_level = 8'd200;
      for (int i = 0; i < TB_AUTO_TO - 1; i++) sendSample(8'd10);
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL auto_early got=%b exp=0", triggered); else passes++;
      bankMem[1-frontBank][0] = 8'd10;
      sendSample(8'd10);
      checks++; if (triggered !== 1'b1) $display("[TB] FAIL auto_fire got=%b exp=1", triggered); else passes++;
      for (int i = 1; i < 800; i++) begin
         bankMem[1-frontBank][i] = 8'd10;
         sendSample(8'd10);
      end
      frameStart();
      frontBank ^= 1;
      checks++; if (auto_trig !== 1'b1) $display("[TB] FAIL auto_flag got=%b exp=1", auto_trig); else passes++;
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL auto_rearm got=%b exp=0", triggered); else passes++;
      foreach (rows[r]) begin
         pipeQ.delete();
         for (int k = 0; k <= 807; k++) begin
            pixelStep(k, rows[r], k <= 805, rdy, got, exp);
            if (rdy) begin
               checks++;
               if (got !== exp) $display("[TB] FAIL auto_pix x=%0d y=%0d got=%h exp=%h", k-2, rows[r], got, exp);
               else passes++;
            end
         end
      end
   endtask

   // Reset in the middle of a capture; the front bank still renders
   task test_reset_mid_capture;
      int rows [2] = '{417, 387};
      trig_level = 8'd40;
      sendSample(8'd0);
      bankMem[1-frontBank][0] = 8'd50;
      sendSample(8'd50);
      for (int i = 1; i < 400; i++) begin
         bankMem[1-frontBank][i] = 8'(i * 3);
         sendSample(8'(i * 3));
      end
      checks++; if (triggered !== 1'b1) $display("[TB] FAIL rstmid_capture got=%b exp=1", triggered); else passes++;
      rst = 1'b1;
      run = 1'b0;
      @(negedge clk);
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL rstmid_trig got=%b exp=0", triggered); else passes++;
      checks++; if (RGB !== 24'h0) $display("[TB] FAIL rstmid_rgb got=%h exp=000000", RGB); else passes++;
      checks++; if (auto_trig !== 1'b0) $display("[TB] FAIL rstmid_auto got=%b exp=0", auto_trig); else passes++;
      rst = 1'b0;
      frontBank = 0;
      repeat (3) @(negedge clk);
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL rstmid_idle got=%b exp=0", triggered); else passes++;
      foreach (rows[r]) begin
         pipeQ.delete();
         for (int k = 0; k <= 807; k++) begin
            pixelStep(k, rows[r], k <= 805, rdy, got, exp);
            if (rdy) begin
               checks++;
               if (got !== exp) $display("[TB] FAIL rstmid_pix x=%0d y=%0d got=%h exp=%h", k-2, rows[r], got, exp);
               else passes++;
            end
         end
      end
   endtask

   // Single shot: arm ignored mid-capture, old bank shown until frame start, column fill
   task test_single_shot;
      rec[0] = 8'd50;
      rec[1] = 8'd150;
      for (int i = 2; i < 800; i++) rec[i] = 8'((i * 37 + 20) & 255);
      pulseArm();
      sendSample(8'd0);
      for (int i = 0; i < 400; i++) begin
         bankMem[1-frontBank][i] = rec[i];
         sendSample(rec[i]);
      end
      arm = 1'b1;
      bankMem[1-frontBank][400] = rec[400];
      sendSample(rec[400]);
      arm = 1'b0;
      checks++; if (triggered !== 1'b1) $display("[TB] FAIL single_armign got=%b exp=1", triggered); else passes++;
      for (int i = 401; i < 799; i++) begin
         bankMem[1-frontBank][i] = rec[i];
         sendSample(rec[i]);
      end
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) begin
            bankMem[1-frontBank][799] = rec[799];
            sendSample(rec[799]);
            checks++; if (triggered !== 1'b1) $display("[TB] FAIL single_hold got=%b exp=1", triggered); else passes++;
         end
         pipeQ.delete();
         for (int k = 0; k <= 807; k++) begin
            pixelStep(k, 417, k <= 805, rdy, got, exp);
            if (rdy) begin
               checks++;
               if (got !== exp) $display("[TB] FAIL single_oldbank p=%0d x=%0d got=%h exp=%h", pass, k-2, got, exp);
               else passes++;
            end
         end
      end
      frameStart();
      frontBank ^= 1;
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL single_idle got=%b exp=0", triggered); else passes++;
      checks++; if (auto_trig !== 1'b0) $display("[TB] FAIL single_auto got=%b exp=0", auto_trig); else passes++;
      checks++; if (expPix(1, 277) !== TRACE || expPix(1, 378) === TRACE || expPix(64, 100) !== GRID)
         $display("[TB] FAIL single_model got=%h exp=%h", expPix(1, 277), TRACE); else passes++;
      for (int y = 270; y <= 385; y++) begin
         pipeQ.delete();
         for (int k = 0; k <= 4; k++) begin
            pixelStep(k, y, k <= 2, rdy, got, exp);
            if (rdy) begin
               checks++;
               if (got !== exp) $display("[TB] FAIL single_col x=%0d y=%0d got=%h exp=%h", k-2, y, got, exp);
               else passes++;
            end
         end
      end
      pipeQ.delete();
      for (int k = 0; k <= 72; k++) begin
         pixelStep(k, 100, k <= 70, rdy, got, exp);
         if (rdy) begin
            checks++;
            if (got !== exp) $display("[TB] FAIL single_grid x=%0d got=%h exp=%h", k-2, got, exp);
            else passes++;
         end
      end
      pipeQ.delete();
      for (int k = 0; k <= 42; k++) begin
         pixelStep(k, 387, k <= 40, rdy, got, exp);
         if (rdy) begin
            checks++;
            if (got !== exp) $display("[TB] FAIL single_level x=%0d got=%h exp=%h", k-2, got, exp);
            else passes++;
         end
      end
      sendSample(8'd0);
      sendSample(8'd200);
      checks++; if (triggered !== 1'b0) $display("[TB] FAIL single_noarm got=%b exp=0", triggered); else passes++;
      pulseArm();
      sendSample(8'd0);
      sendSample(8'd100);
      checks++; if (triggered !== 1'b1) $display("[TB] FAIL single_rearm got=%b exp=1", triggered); else passes++;
   endtask

   // Test sequence
   initial begin
      @(negedge clk);
      test_reset();
      test_ramp();
      test_auto();
      test_reset_mid_capture();
      test_single_shot();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
